fnd_scan_sched: RTL and testbench

Sequencing controller for the 4-digit FND display behind the APB FND peripheral. It replaces the free-running divider/counter/divide-based decode path with three parts: a prescaled digit-scan state machine with dead-time blanking, an iterative binary-to-BCD converter using a load/busy handshake, and per-digit font generation with decimal point and leading-zero blanking. The APB register block drives its inputs. Its outputs drive the FND pins directly.

---
 rtl/fnd_scan_sched_if.sv | 26 ++
 rtl/fnd_scan_sched.sv | 172 +++++++++++++++++
 tb/tb_fnd_scan_sched.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_sched_if.sv
// Bus between the APB FND register block (master) and the scan scheduler (slave).
// data_load is a one-cycle start strobe with no ready: a load while busy restarts the conversion.
interface fnd_scan_sched_if #(
    parameter int DATA_W = 14
);
    logic              en;
    logic [DATA_W-1:0] data;
    logic              data_load;
    logic [3:0]        dp_mask;
    logic              lz_blank;
    logic [15:0]       bcd;
    logic              busy;
    logic [3:0]        FND_comm;
    logic [7:0]        FND_font;
    logic [1:0]        scan_state;

    modport master (
        output en, data, data_load, dp_mask, lz_blank,
        input  bcd, busy, FND_comm, FND_font, scan_state
    );

    modport slave (
        input  en, data, data_load, dp_mask, lz_blank,
        output bcd, busy, FND_comm, FND_font, scan_state
    );
endinterface

// File: rtl/fnd_scan_sched.sv
// 4-digit FND sequencer: prescaled scan FSM with blanking, iterative binary-to-BCD
// converter and per-digit font generation with decimal point and leading-zero blanking.
module fnd_scan_sched #(
    parameter int DIV       = 100000,
    parameter int BLANK_CYC = 500,
    parameter int DATA_W    = 14
) (
    input  logic              PCLK,
    input  logic              PRESET,
    fnd_scan_sched_if.slave   bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC + 1) : 1;
    localparam int CW = $clog2(DATA_W + 1);
    localparam int SW = 16 + DATA_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blank_q, blank_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    comm_q, comm_d;
    logic [7:0]    font_q, font_d;
    logic          slot_end, blank_done;

    // Working shift register: {bcd digits, remaining binary bits}
    logic [SW-1:0] sr_q, sr_d;
    logic [15:0]   adj;
    logic [15:0]   bcd_q, bcd_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0]    nib;
    logic          lz_hit;
    logic [7:0]    lat_font;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    assign slot_end   = (presc_q == PW'(DIV - 1));
    assign blank_done = (blank_q == BW'(BLANK_CYC - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE:  state_d = ST_BLANK;
            ST_BLANK: if (blank_done) state_d = ST_DRIVE;
            ST_DRIVE: if (slot_end) begin
                state_d = ST_BLANK;
                idx_d   = idx_q + 2'd1;
            end
            default:  state_d = ST_IDLE;
        endcase
        if (!bus.en) begin
            state_d = ST_IDLE;
        end

        if (state_d == ST_IDLE) begin
            presc_d = '0;
            blank_d = '0;
            idx_d   = 2'd0;
        end else begin
            presc_d = (state_q == ST_IDLE || slot_end) ? '0 : presc_q + PW'(1);
            blank_d = (state_q == ST_BLANK && state_d == ST_BLANK) ? blank_q + BW'(1) : '0;
        end
    end

    // Digit font is fixed at the BLANK->DRIVE edge so a mid-slot commit cannot tear the digit.
    always_comb begin
        nib = bcd_q[{idx_q, 2'b00} +: 4];
        case (idx_q)
            2'd3:    lz_hit = (bcd_q[15:12] == 4'd0);
            2'd2:    lz_hit = (bcd_q[15:8] == 8'd0);
            2'd1:    lz_hit = (bcd_q[15:4] == 12'd0);
            default: lz_hit = 1'b0;
        endcase
        lz_hit = lz_hit & bus.lz_blank;
        if (nib > 4'd9) begin
            lat_font = 8'hFF;
        end else if (lz_hit) begin
            lat_font = {~bus.dp_mask[idx_q], 7'h7F};
        end else begin
            lat_font = {~bus.dp_mask[idx_q], seg_of(nib)};
        end
    end

    always_comb begin
        comm_d = 4'hF;
        font_d = 8'hFF;
        if (state_d == ST_DRIVE) begin
            if (state_q == ST_DRIVE) begin
                comm_d = comm_q;
                font_d = font_q;
            end else begin
                comm_d = ~(4'b0001 << idx_q);
                font_d = lat_font;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            adj[4*k +: 4] = (sr_q[DATA_W + 4*k +: 4] >= 4'd5) ?
                            sr_q[DATA_W + 4*k +: 4] + 4'd3 : sr_q[DATA_W + 4*k +: 4];
        end
        sr_d   = sr_q;
        bcd_d  = bcd_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (bus.data_load) begin
            sr_d   = {16'h0000, (32'(bus.data) > 32'd9999) ? DATA_W'(9999) : bus.data};
            busy_d = 1'b1;
            cnt_d  = CW'(DATA_W);
        end else if (busy_q) begin
            sr_d  = {adj, sr_q[DATA_W-1:0]} << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                bcd_d  = sr_d[SW-1 -: 16];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            blank_q <= '0;
            idx_q   <= 2'd0;
            comm_q  <= 4'hF;
            font_q  <= 8'hFF;
            sr_q    <= '0;
            bcd_q   <= 16'h0000;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            blank_q <= blank_d;
            idx_q   <= idx_d;
            comm_q  <= comm_d;
            font_q  <= font_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.bcd        = bcd_q;
    assign bus.busy       = busy_q;
    assign bus.FND_comm   = comm_q;
    assign bus.FND_font   = font_q;
    assign bus.scan_state = state_q;
endmodule

// File: tb/tb_fnd_scan_sched.sv
// Directed bench for fnd_scan_sched with DIV=8, BLANK_CYC=2: scan order, conversion, restart,
// leading-zero blanking, enable drop and reset.
module tb_fnd_scan_sched;
    localparam int DIV       = 8;
    localparam int BLANK_CYC = 2;
    localparam int DATA_W    = 14;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fnd_scan_sched_if #(.DATA_W(DATA_W)) bus ();

    fnd_scan_sched #(.DIV(DIV), .BLANK_CYC(BLANK_CYC), .DATA_W(DATA_W)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_load(input logic [DATA_W-1:0] v);
        bus.data      = v;
        bus.data_load = 1'b1;
        @(negedge clk);
        bus.data_load = 1'b0;
    endtask

    task automatic wait_busy_done(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.FND_comm !== 4'hF) begin errors++; $display("FAIL reset_comm got=%h exp=F", bus.FND_comm); end
        checks++; if (bus.FND_font !== 8'hFF) begin errors++; $display("FAIL reset_font got=%h exp=FF", bus.FND_font); end
        checks++; if (bus.bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got=%h exp=0000", bus.bcd); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.scan_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.scan_state); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_convert;
        int n;
        do_load(14'd9876);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL conv_busy_start got=%b exp=1", bus.busy); end
        wait_busy_done(n);
        checks++; if (n != 14) begin errors++; $display("FAIL conv_busy_len got=%0d exp=14", n); end
        checks++; if (bus.bcd !== 16'h9876) begin errors++; $display("FAIL conv_9876 got=%h exp=9876", bus.bcd); end
        do_load(14'd12000);
        checks++; if (bus.bcd !== 16'h9876) begin errors++; $display("FAIL conv_hold got=%h exp=9876", bus.bcd); end
        wait_busy_done(n);
        checks++; if (n != 14) begin errors++; $display("FAIL conv_clamp_len got=%0d exp=14", n); end
        checks++; if (bus.bcd !== 16'h9999) begin errors++; $display("FAIL conv_clamp got=%h exp=9999", bus.bcd); end
    endtask

    task automatic test_restart;
        int n;
        do_load(14'd1111);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.bcd !== 16'h9999) begin errors++; $display("FAIL restart_hold1 cyc=%0d got=%h exp=9999", i, bus.bcd); end
            @(negedge clk);
        end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL restart_busy got=%b exp=1", bus.busy); end
        do_load(14'd42);
        n = 0;
        while (bus.busy && n < 200) begin
            checks++; if (bus.bcd !== 16'h9999) begin errors++; $display("FAIL restart_hold2 cyc=%0d got=%h exp=9999", n, bus.bcd); end
            n++;
            @(negedge clk);
        end
        checks++; if (n != 14) begin errors++; $display("FAIL restart_busy_len got=%0d exp=14", n); end
        checks++; if (bus.bcd !== 16'h0042) begin errors++; $display("FAIL restart_final got=%h exp=0042", bus.bcd); end
    endtask

    task automatic test_scan;
        int n;
        logic [7:0] exp_font [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        logic [3:0] exp_comm;
        logic [7:0] exp_f;
        do_load(14'd1234);
        wait_busy_done(n);
        checks++; if (bus.bcd !== 16'h1234) begin errors++; $display("FAIL scan_bcd got=%h exp=1234", bus.bcd); end
        checks++; if (bus.FND_comm !== 4'hF) begin errors++; $display("FAIL scan_idle_comm got=%h exp=F", bus.FND_comm); end
        bus.en = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 40; j++) begin
            int pos, dig;
            pos = j % 8;
            dig = (j / 8) % 4;
            exp_comm = (pos < 2) ? 4'hF : ~(4'b0001 << dig);
            exp_f    = (pos < 2) ? 8'hFF : exp_font[dig];
            checks++; if (bus.FND_comm !== exp_comm) begin errors++; $display("FAIL scan_comm cyc=%0d got=%h exp=%h", j, bus.FND_comm, exp_comm); end
            checks++; if (bus.FND_font !== exp_f) begin errors++; $display("FAIL scan_font cyc=%0d got=%h exp=%h", j, bus.FND_font, exp_f); end
            @(negedge clk);
        end
        bus.en = 1'b0;
        @(negedge clk);
        checks++; if (bus.scan_state !== 2'd0) begin errors++; $display("FAIL scan_stop_state got=%0d exp=0", bus.scan_state); end
    endtask

    task automatic test_lz_blank;
        int n;
        logic [7:0] lz_font [4] = '{8'hF8, 8'hFF, 8'h7F, 8'hFF};
        logic [7:0] nz_font [4] = '{8'hF8, 8'hC0, 8'h40, 8'hC0};
        logic [7:0] exp_f;
        do_load(14'd7);
        wait_busy_done(n);
        checks++; if (bus.bcd !== 16'h0007) begin errors++; $display("FAIL lz_bcd got=%h exp=0007", bus.bcd); end
        bus.dp_mask  = 4'b0100;
        bus.lz_blank = 1'b1;
        bus.en       = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 32; j++) begin
            exp_f = ((j % 8) < 2) ? 8'hFF : lz_font[(j / 8) % 4];
            checks++; if (bus.FND_font !== exp_f) begin errors++; $display("FAIL lz_on_font cyc=%0d got=%h exp=%h", j, bus.FND_font, exp_f); end
            @(negedge clk);
        end
        bus.en = 1'b0;
        @(negedge clk);
        bus.lz_blank = 1'b0;
        bus.en       = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 32; j++) begin
            exp_f = ((j % 8) < 2) ? 8'hFF : nz_font[(j / 8) % 4];
            checks++; if (bus.FND_font !== exp_f) begin errors++; $display("FAIL lz_off_font cyc=%0d got=%h exp=%h", j, bus.FND_font, exp_f); end
            @(negedge clk);
        end
        bus.en = 1'b0;
        bus.dp_mask = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_en_drop;
        logic [3:0] exp_comm;
        logic [7:0] exp_f;
        bus.en = 1'b1;
        @(negedge clk);
        repeat (20) @(negedge clk);
        checks++; if (bus.FND_comm !== 4'hB) begin errors++; $display("FAIL drop_pre_comm got=%h exp=B", bus.FND_comm); end
        bus.en = 1'b0;
        @(negedge clk);
        checks++; if (bus.FND_comm !== 4'hF) begin errors++; $display("FAIL drop_comm got=%h exp=F", bus.FND_comm); end
        checks++; if (bus.FND_font !== 8'hFF) begin errors++; $display("FAIL drop_font got=%h exp=FF", bus.FND_font); end
        checks++; if (bus.scan_state !== 2'd0) begin errors++; $display("FAIL drop_state got=%0d exp=0", bus.scan_state); end
        repeat (3) @(negedge clk);
        checks++; if (bus.FND_comm !== 4'hF) begin errors++; $display("FAIL drop_hold_comm got=%h exp=F", bus.FND_comm); end
        bus.en = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            exp_comm = ((j % 8) < 2) ? 4'hF : 4'hE;
            exp_f    = ((j % 8) < 2) ? 8'hFF : 8'hF8;
            checks++; if (bus.FND_comm !== exp_comm) begin errors++; $display("FAIL resume_comm cyc=%0d got=%h exp=%h", j, bus.FND_comm, exp_comm); end
            checks++; if (bus.FND_font !== exp_f) begin errors++; $display("FAIL resume_font cyc=%0d got=%h exp=%h", j, bus.FND_font, exp_f); end
            @(negedge clk);
        end
        bus.en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_preset;
        bus.en = 1'b1;
        @(negedge clk);
        repeat (17) @(negedge clk);
        do_load(14'd9876);
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL preset_pre_busy got=%b exp=1", bus.busy); end
        checks++; if (bus.FND_comm !== 4'hB) begin errors++; $display("FAIL preset_pre_comm got=%h exp=B", bus.FND_comm); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.FND_comm !== 4'hF) begin errors++; $display("FAIL preset_comm got=%h exp=F", bus.FND_comm); end
        checks++; if (bus.FND_font !== 8'hFF) begin errors++; $display("FAIL preset_font got=%h exp=FF", bus.FND_font); end
        checks++; if (bus.bcd !== 16'h0000) begin errors++; $display("FAIL preset_bcd got=%h exp=0000", bus.bcd); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL preset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.scan_state !== 2'd0) begin errors++; $display("FAIL preset_state got=%0d exp=0", bus.scan_state); end
        rst = 1'b0;
        bus.en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.data      = '0;
        bus.data_load = 1'b0;
        bus.dp_mask   = 4'b0000;
        bus.lz_blank  = 1'b0;
        @(negedge clk);
        test_reset();
        test_convert();
        test_restart();
        test_scan();
        test_lz_blank();
        test_en_drop();
        test_preset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
